// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the ALU issue logic and the multiply/divide sequencer.
// Latency: none, wires only.
// Backpressure: none; the issuer must not expect a new start to be taken while busy is high.
//
// Signals (named from the sequencer's point of view):
//   start  : request pulse, taken only when the sequencer is idle or finishing
//   op     : 0 = unsigned multiply, 1 = unsigned divide
//   a, b   : multiplicand/dividend and multiplier/divisor
//   busy   : operation in progress
//   done   : one-cycle completion pulse
//   res_lo : product low half, or quotient
//   res_hi : product high half, or remainder
interface muldiv_seq_if #(
    parameter int n = 4
);
    logic         start;
    logic         op;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         busy;
    logic         done;
    logic [n-1:0] res_lo;
    logic [n-1:0] res_hi;

    // Issuer side: ALU or testbench.
    modport master (
        output start, op, a, b,
        input  busy, done, res_lo, res_hi
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b,
        output busy, done, res_lo, res_hi
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) around one shared adder.
// Latency: start accepted at edge E0, busy through edge E0+n, done pulses in the cycle after E0+n.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset; aborts any operation, clears results
//   bus    : muldiv_seq_if.slave (start/op/a/b in, busy/done/res_lo/res_hi out)
module muldiv_seq #(
    parameter int n = 4
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_seq_if.slave   bus
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    // Only one operand feeds the adder: multiplicand for mul, divisor for div.
    logic [n-1:0]  opnd_q, opnd_d;
    // hi/lo form the 2n-bit working register: {product} or {remainder, quotient}.
    logic [n-1:0]  hi_q, hi_d;
    logic [n-1:0]  lo_q, lo_d;

    // Shared adder connections.
    logic [n-1:0]  add_x;
    logic [n-1:0]  add_sum;
    logic          add_carry;
    logic          add_ltu;
    logic          add_ovf_unused;
    logic          add_eq_unused;
    logic          add_lt_unused;

    // Divide: {m, R, Q} = {R, Q, 0}.
    logic [2*n:0]  div_shift;
    logic          div_m;
    logic [n-1:0]  div_r;
    logic [n-1:0]  div_q;
    logic          div_take;

    // Multiply: {carry, sum_or_hi, lo} shifted right by one.
    logic [2*n:0]  mul_cat;

    assign div_shift = {hi_q, lo_q, 1'b0};
    assign div_m     = div_shift[2*n];
    assign div_r     = div_shift[2*n-1:n];
    assign div_q     = div_shift[n-1:0];

    // Subtract for divide, add for multiply; op_q doubles as the Nadd_sub control.
    assign add_x = op_q ? div_r : hi_q;

    adder #(.n(n)) u_adder (
        .x_i        (add_x),
        .y_i        (opnd_q),
        .Nadd_sub_i (op_q),
        .sum_o      (add_sum),
        .carry_o    (add_carry),
        .overflow_o (add_ovf_unused),
        .eq_o       (add_eq_unused),
        .lt_o       (add_lt_unused),
        .ltu_o      (add_ltu)
    );

    // A bit shifted out of R means the true partial remainder is >= 2^n > b,
    // so the subtraction is taken regardless of the n-bit compare.
    assign div_take = div_m | ~add_ltu;

    // Skip the addition when the multiplier bit is clear: keep hi, carry 0.
    assign mul_cat = lo_q[0] ? {add_carry, add_sum, lo_q} : {1'b0, hi_q, lo_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = bus.op;
                    opnd_d  = bus.op ? bus.b : bus.a;
                    hi_d    = '0;
                    lo_d    = bus.op ? bus.a : bus.b;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
                if (op_q) begin
                    hi_d = div_take ? add_sum : div_r;
                    lo_d = div_q | n'(div_take);
                end else begin
                    hi_d = mul_cat[2*n:n+1];
                    lo_d = mul_cat[n:1];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Status and results come straight from registers, so reset clears them at once.
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.res_lo = lo_q;
    assign bus.res_hi = hi_q;
endmodule

// n-bit adder/subtractor with flags; Nadd_sub_i = 1 computes x - y.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   x_i, y_i    : operands
//   Nadd_sub_i  : 0 = add, 1 = subtract
//   sum_o       : result
//   carry_o     : carry out (for subtract, 1 means no borrow)
//   overflow_o  : signed overflow
//   eq_o        : x == y
//   lt_o        : signed x < y (meaningful when subtracting)
//   ltu_o       : unsigned x < y (meaningful when subtracting)
module adder #(
    parameter int n = 4
) (
    input  logic [n-1:0] x_i,
    input  logic [n-1:0] y_i,
    input  logic         Nadd_sub_i,
    output logic [n-1:0] sum_o,
    output logic         carry_o,
    output logic         overflow_o,
    output logic         eq_o,
    output logic         lt_o,
    output logic         ltu_o
);
    logic [n-1:0] y_eff;
    logic [n:0]   full;

    // Two's-complement subtract: invert y and inject the +1 as carry-in.
    assign y_eff      = Nadd_sub_i ? ~y_i : y_i;
    assign full       = {1'b0, x_i} + {1'b0, y_eff} + {{n{1'b0}}, Nadd_sub_i};
    assign sum_o      = full[n-1:0];
    assign carry_o    = full[n];
    assign overflow_o = (x_i[n-1] == y_eff[n-1]) && (sum_o[n-1] != x_i[n-1]);
    assign eq_o       = (x_i == y_i);
    assign lt_o       = sum_o[n-1] ^ overflow_o;
    assign ltu_o      = ~full[n];
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq with n = 4 and hand-computed results.
// Latency: drives and samples on the falling clock edge.
// Backpressure: exercises start during busy and start during the done cycle.
module tb_muldiv_seq;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    muldiv_seq_if #(.n(N)) mif ();

    muldiv_seq #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents a request for one rising edge and
    // checks that the sequencer went busy after it.
    task automatic start_op(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        @(negedge clk);
        mif.start = 1'b0;
        chk("busy_after_start", 8'(mif.busy), 8'd1);
        chk("done_after_start", 8'(mif.done), 8'd0);
    endtask

    // Called right after start_op; checks the remaining busy cycles and the
    // done cycle with its results.
    task automatic wait_result(input string tag, input logic [N-1:0] exp_lo, input logic [N-1:0] exp_hi);
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            chk({tag, "_busy_run"}, 8'(mif.busy), 8'd1);
        end
        @(negedge clk);
        chk({tag, "_done"},   8'(mif.done),   8'd1);
        chk({tag, "_busy0"},  8'(mif.busy),   8'd0);
        chk({tag, "_res_lo"}, 8'(mif.res_lo), 8'(exp_lo));
        chk({tag, "_res_hi"}, 8'(mif.res_hi), 8'(exp_hi));
    endtask

    // One cycle after done with no start: back to idle, results held.
    task automatic idle_check(input string tag, input logic [N-1:0] exp_lo, input logic [N-1:0] exp_hi);
        @(negedge clk);
        chk({tag, "_idle_done"}, 8'(mif.done),   8'd0);
        chk({tag, "_idle_busy"}, 8'(mif.busy),   8'd0);
        chk({tag, "_hold_lo"},   8'(mif.res_lo), 8'(exp_lo));
        chk({tag, "_hold_hi"},   8'(mif.res_hi), 8'(exp_hi));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        mif.start = 1'b0;
        mif.op    = 1'b0;
        mif.a     = '0;
        mif.b     = '0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",   8'(mif.busy),   8'd0);
        chk("rst_done",   8'(mif.done),   8'd0);
        chk("rst_res_lo", 8'(mif.res_lo), 8'd0);
        chk("rst_res_hi", 8'(mif.res_hi), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // 15 * 15 = 225 = 0xE1
        start_op(1'b0, 4'd15, 4'd15);
        wait_result("mul15x15", 4'h1, 4'hE);
        idle_check("mul15x15", 4'h1, 4'hE);

        // 13 / 3 = 4 rem 1
        start_op(1'b1, 4'd13, 4'd3);
        wait_result("div13by3", 4'd4, 4'd1);
        idle_check("div13by3", 4'd4, 4'd1);

        // 15 / 1 = 15 rem 0
        start_op(1'b1, 4'd15, 4'd1);
        wait_result("div15by1", 4'd15, 4'd0);
        idle_check("div15by1", 4'd15, 4'd0);

        // 9 / 0: quotient all ones, remainder = dividend
        start_op(1'b1, 4'd9, 4'd0);
        wait_result("div9by0", 4'hF, 4'd9);
        idle_check("div9by0", 4'hF, 4'd9);

        // 6 * 7 = 42 = 0x2A with two ignored starts while busy
        start_op(1'b0, 4'd6, 4'd7);
        mif.start = 1'b1; mif.op = 1'b1; mif.a = 4'd1; mif.b = 4'd2;
        @(negedge clk);
        chk("busy_start1_busy", 8'(mif.busy), 8'd1);
        mif.start = 1'b0;
        @(negedge clk);
        chk("busy_start_mid_busy", 8'(mif.busy), 8'd1);
        mif.start = 1'b1; mif.op = 1'b0; mif.a = 4'd9; mif.b = 4'd9;
        @(negedge clk);
        chk("busy_start2_busy", 8'(mif.busy), 8'd1);
        mif.start = 1'b0;
        @(negedge clk);
        chk("mul6x7_done",   8'(mif.done),   8'd1);
        chk("mul6x7_res_lo", 8'(mif.res_lo), 8'hA);
        chk("mul6x7_res_hi", 8'(mif.res_hi), 8'h2);

        // Back-to-back: start in the done cycle, 14 / 4 = 3 rem 2
        start_op(1'b1, 4'd14, 4'd4);
        wait_result("div14by4", 4'd3, 4'd2);
        idle_check("div14by4", 4'd3, 4'd2);

        // Asynchronous reset in the second RUN cycle, between edges
        start_op(1'b1, 4'd13, 4'd3);
        @(negedge clk);
        chk("pre_rst_busy", 8'(mif.busy), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy",   8'(mif.busy),   8'd0);
        chk("async_rst_done",   8'(mif.done),   8'd0);
        chk("async_rst_res_lo", 8'(mif.res_lo), 8'd0);
        chk("async_rst_res_hi", 8'(mif.res_hi), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_busy", 8'(mif.busy), 8'd0);

        // Fresh 5 * 3 = 15 after reset
        start_op(1'b0, 4'd5, 4'd3);
        wait_result("mul5x3", 4'd15, 4'd0);
        idle_check("mul5x3", 4'd15, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
